// File: rtl/imem_line_responder.sv
// Memory-side line-fill responder: accepts one line read, waits LATENCY cycles, returns NUM_BLOCKS words.
// Optional RESP_STATS_EN adds request/abort counters. The backing store is filled through the ld_* port.
module imem_line_responder #(
    parameter int    NUM_BLOCKS = 4,
    parameter int    BLOCK_SIZE = 4,
    parameter int    MEM_WORDS  = 16384,
    parameter int    LATENCY    = 4,
    parameter string INIT_FILE  = "imem.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_req_valid,
    output logic                    mem_req_ready,
    input  logic [31:0]             mem_req_addr,
    output logic [32*NUM_BLOCKS-1:0] mem_req_rdata,
    input  logic                    ld_valid,
    input  logic [31:0]             ld_addr,
    input  logic [31:0]             ld_data
`ifdef RESP_STATS_EN
    ,
    output logic [31:0]             stat_reqs,
    output logic [31:0]             stat_aborts
`endif
);
    localparam int AW   = $clog2(MEM_WORDS);
    localparam int BOFF = $clog2(BLOCK_SIZE);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} state_t;

    state_t                          state_q;
    logic [7:0]                      cnt_q;
    logic [AW-1:0]                   base_q;
    logic [NUM_BLOCKS-1:0][31:0]     line_q;
    logic [31:0]                     mem [MEM_WORDS];

    logic [AW-1:0] req_idx, req_base, ld_idx;
    logic          accept, abort;

    assign req_idx  = mem_req_addr[BOFF +: AW];
    assign req_base = req_idx & ~AW'(NUM_BLOCKS - 1);
    assign ld_idx   = ld_addr[BOFF +: AW];
    assign accept   = (state_q == IDLE) && mem_req_valid;
    assign abort    = (state_q == WAIT) && !mem_req_valid;

    // Address bits outside the word index are don't-care by design.
    logic unused_addr_bits;
    assign unused_addr_bits = &{mem_req_addr[31:BOFF+AW], mem_req_addr[BOFF-1:0],
                                ld_addr[31:BOFF+AW], ld_addr[BOFF-1:0]};

    assign mem_req_rdata = line_q;

    // Store has no reset; a load on the response edge lands after the line read (old data returned).
    always_ff @(posedge clk) begin
        if (ld_valid)
            mem[ld_idx] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            base_q        <= '0;
            line_q        <= '0;
            mem_req_ready <= 1'b0;
        end else begin
            mem_req_ready <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_req_valid) begin
                        base_q  <= req_base;
                        cnt_q   <= 8'(LATENCY - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!mem_req_valid) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 8'd0) begin
                        for (int k = 0; k < NUM_BLOCKS; k++)
                            line_q[k] <= mem[base_q | AW'(k)];
                        mem_req_ready <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                RESP:    state_q <= DRAIN;
                DRAIN:   if (!mem_req_valid) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef RESP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_reqs   <= '0;
            stat_aborts <= '0;
        end else begin
            if (accept) stat_reqs   <= stat_reqs + 32'd1;
            if (abort)  stat_aborts <= stat_aborts + 32'd1;
        end
    end
`else
    logic unused_strobes;
    assign unused_strobes = accept ^ abort;
`endif

endmodule

// File: tb/tb_imem_line_responder.sv
// Directed bench: three responders (LATENCY 4, 1, 255) share stimulus; each phase checks one of them.
module tb_imem_line_responder;
    logic         clk = 1'b0;
    logic         reset, valid, ld_valid;
    logic [31:0]  addr, ld_addr, ld_data;
    logic         r4, r1, r255;
    logic [127:0] d4, d1, d255;
`ifdef RESP_STATS_EN
    logic [31:0]  sq4, sa4, sq1, sa1, sq255, sa255;
`endif

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] A0 = 32'h1111_A0A0, A1 = 32'h2222_A1A1,
                            A2 = 32'h3333_A2A2, A3 = 32'h4444_A3A3,
                            BEEF = 32'h0000_BEEF;

    always #5 clk = ~clk;

    imem_line_responder #(.NUM_BLOCKS(4), .MEM_WORDS(16384), .LATENCY(4), .INIT_FILE("")) u_l4 (
        .clk(clk), .reset(reset), .mem_req_valid(valid), .mem_req_ready(r4), .mem_req_addr(addr),
        .mem_req_rdata(d4), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef RESP_STATS_EN
        , .stat_reqs(sq4), .stat_aborts(sa4)
`endif
    );
    imem_line_responder #(.NUM_BLOCKS(4), .MEM_WORDS(16384), .LATENCY(1), .INIT_FILE("")) u_l1 (
        .clk(clk), .reset(reset), .mem_req_valid(valid), .mem_req_ready(r1), .mem_req_addr(addr),
        .mem_req_rdata(d1), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef RESP_STATS_EN
        , .stat_reqs(sq1), .stat_aborts(sa1)
`endif
    );
    imem_line_responder #(.NUM_BLOCKS(4), .MEM_WORDS(16384), .LATENCY(255), .INIT_FILE("")) u_l255 (
        .clk(clk), .reset(reset), .mem_req_valid(valid), .mem_req_ready(r255), .mem_req_addr(addr),
        .mem_req_rdata(d255), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef RESP_STATS_EN
        , .stat_reqs(sq255), .stat_aborts(sa255)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int lat);
        case (lat)
            1:       rdy = r1;
            255:     rdy = r255;
            default: rdy = r4;
        endcase
    endfunction

    function automatic logic [127:0] dat(input int lat);
        case (lat)
            1:       dat = d1;
            255:     dat = d255;
            default: dat = d4;
        endcase
    endfunction

    // Request held through LATENCY+4 cycles (3 extra in DRAIN); address scrambled after acceptance.
    task automatic do_req(input logic [31:0] a, input int lat, input logic [127:0] exp_line,
                          input string tag);
        int pulses, at;
        logic [127:0] line;
        pulses = 0; at = 0; line = '0;
        valid = 1'b1; addr = a;
        tick();
        addr = 32'hDEAD_BEE0;
        for (int i = 1; i <= lat + 4; i++) begin
            if (rdy(lat)) begin
                pulses++;
                if (at == 0) begin at = i; line = dat(lat); end
            end
            tick();
        end
        valid = 1'b0;
        tick(); tick();
        chk({tag, "_pulses"}, 128'(pulses), 128'd1);
        chk({tag, "_cycle"},  128'(at), 128'(lat + 1));
        chk({tag, "_line"},   line, exp_line);
        chk({tag, "_held"},   dat(lat), exp_line);
    endtask

    initial begin
        int pulses;
        reset = 1'b1; valid = 1'b0; addr = '0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_ready", 128'(r4), 128'd0);
        chk("rst_rdata", d4, 128'd0);
`ifdef RESP_STATS_EN
        chk("rst_reqs",   128'(sq4), 128'd0);
        chk("rst_aborts", 128'(sa4), 128'd0);
`endif

        // Preload line 0x100..0x10C
        ld_valid = 1'b1;
        ld_addr = 32'h100; ld_data = A0; tick();
        ld_addr = 32'h104; ld_data = A1; tick();
        ld_addr = 32'h108; ld_data = A2; tick();
        ld_addr = 32'h10C; ld_data = A3; tick();
        ld_valid = 1'b0;

        do_req(32'h108, 4, {A3, A2, A1, A0}, "basic");
        do_req(32'h100, 4, {A3, A2, A1, A0}, "again");

        // Abort: accepted, one WAIT cycle, valid dropped
        valid = 1'b1; addr = 32'h100;
        tick(); tick();
        valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (r4) pulses++;
            tick();
        end
        chk("abort_no_ready", 128'(pulses), 128'd0);
`ifdef RESP_STATS_EN
        chk("abort_reqs",   128'(sq4), 128'd3);
        chk("abort_aborts", 128'(sa4), 128'd1);
`endif
        do_req(32'h104, 4, {A3, A2, A1, A0}, "post_abort");

        // Load collides with the LATENCY=1 read edge: old word returned
        valid = 1'b1; addr = 32'h100;
        tick();
        ld_valid = 1'b1; ld_addr = 32'h100; ld_data = BEEF;
        chk("coll_pre_ready", 128'(r1), 128'd0);
        tick();
        ld_valid = 1'b0;
        chk("coll_ready", 128'(r1), 128'd1);
        chk("coll_line",  d1, {A3, A2, A1, A0});
        valid = 1'b0;
        tick(); tick(); tick();
        do_req(32'h100, 1, {A3, A2, A1, BEEF}, "coll_new");

        // Index wrap and maximum latency
        do_req(32'h0001_0100, 4, {A3, A2, A1, BEEF}, "wrap");
        do_req(32'h108, 255, {A3, A2, A1, BEEF}, "lat255");

        // Reset while waiting
        valid = 1'b1; addr = 32'h100;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; valid = 1'b0;
        chk("mid_rst_rdata4", d4, 128'd0);
        chk("mid_rst_rdata1", d1, 128'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (r4 || r1) pulses++;
            tick();
        end
        chk("mid_rst_no_ready", 128'(pulses), 128'd0);
`ifdef RESP_STATS_EN
        chk("mid_rst_reqs", 128'(sq4), 128'd0);
`endif
        do_req(32'h10C, 4, {A3, A2, A1, BEEF}, "post_rst");
`ifdef RESP_STATS_EN
        chk("final_reqs",   128'(sq4), 128'd1);
        chk("final_aborts", 128'(sa4), 128'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a stuck run
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
